// File: rtl/raw_ring_pkg.sv
// Shared types and default parameters for the raw hit ring buffer.
package raw_ring_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    localparam int MARGIN_DEFAULT = 10;
    localparam int CNTW_DEFAULT   = 16;

endpackage

// File: rtl/raw_ring_buffer_skid.sv
// Two-entry valid/ready skid buffer that absorbs the one-cycle RAM read latency.
module raw_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   level
);

    logic [W-1:0] data0_reg, data1_reg;
    logic         last0_reg, last1_reg;
    logic [1:0]   cnt_reg;
    logic         pop;

    assign out_valid = (cnt_reg != 2'd0);
    assign out_data  = data0_reg;
    assign out_last  = last0_reg && out_valid;
    assign level     = cnt_reg;
    assign pop       = out_valid && out_ready;

    // The producer never pushes into a full buffer, so no overflow handling here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_reg <= '0;
            data1_reg <= '0;
            last0_reg <= 1'b0;
            last1_reg <= 1'b0;
            cnt_reg   <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt_reg == 2'd0) begin
                        data0_reg <= in_data;
                        last0_reg <= in_last;
                    end else begin
                        data1_reg <= in_data;
                        last1_reg <= in_last;
                    end
                    cnt_reg <= cnt_reg + 2'd1;
                end
                2'b01: begin
                    data0_reg <= data1_reg;
                    last0_reg <= last1_reg;
                    cnt_reg   <= cnt_reg - 2'd1;
                end
                2'b11: begin
                    if (cnt_reg == 2'd1) begin
                        data0_reg <= in_data;
                        last0_reg <= in_last;
                    end else begin
                        data0_reg <= data1_reg;
                        last0_reg <= last1_reg;
                        data1_reg <= in_data;
                        last1_reg <= in_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/raw_ring_buffer.sv
// Circular raw-hit store with overrun protection, guard-band full flag and block readout.
// Optional parity protection of stored words is enabled by defining RAW_RING_PARITY_EN.
module raw_ring_buffer
    import raw_ring_pkg::*;
#(
    parameter int WIDTH  = 288,
    parameter int AW     = 8,
    parameter int MARGIN = MARGIN_DEFAULT,
    parameter int CNTW   = CNTW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] dw,
    output logic [AW-1:0]    wr_ptr,
    input  logic [AW-1:0]    keep_ptr,
    input  logic [AW-1:0]    wblock,
    output logic             full,
    output logic [CNTW-1:0]  drop_cnt,
    input  logic             blk_req,
    input  logic [AW-1:0]    blk_start,
    input  logic [AW-1:0]    blk_len,
    output logic             blk_busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             par_err
);

    localparam int DEPTH = 1 << AW;
`ifdef RAW_RING_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic [AW-1:0]   wr_ptr_reg;
    logic            full_reg;
    logic [CNTW-1:0] drop_reg;
    logic [AW-1:0]   diff;
    logic [AW+1:0]   diff_ext, guard;
    logic            suppress, accept, full_next;
    logic [MW-1:0]   wdata;

    assign diff      = keep_ptr - wr_ptr_reg;
    assign suppress  = we && (diff == AW'(1));
    assign accept    = we && !suppress;
    // Widened compare keeps wblock + MARGIN from wrapping.
    assign diff_ext  = {2'b00, diff};
    assign guard     = {2'b00, wblock} + (AW+2)'(MARGIN);
    assign full_next = !((diff_ext > guard) || (diff == '0));

`ifdef RAW_RING_PARITY_EN
    assign wdata = {^dw, dw};
`else
    assign wdata = dw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            full_reg   <= 1'b0;
            drop_reg   <= '0;
        end else begin
            full_reg <= full_next;
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (suppress && (drop_reg != '1))
                drop_reg <= drop_reg + CNTW'(1);
        end
    end

    assign wr_ptr   = wr_ptr_reg;
    assign full     = full_reg;
    assign drop_cnt = drop_reg;

    rd_state_t     state_reg;
    logic [AW-1:0] start_reg, len_reg, idx_reg;
    logic          rvalid_reg, rlast_reg;
    logic [1:0]    skid_level;
    logic [2:0]    in_flight;
    logic          pop, room, issue, issue_last;
    logic [AW-1:0] raddr;
    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] ram_q;
    logic [MW-1:0] skid_data;

    assign pop        = rd_valid && rd_ready;
    // A word issued now lands in the skid next cycle; count what will still be held then.
    assign in_flight  = {1'b0, skid_level} + {2'b00, rvalid_reg};
    assign room       = in_flight < (3'd2 + {2'b00, pop});
    assign issue      = (state_reg == ST_RUN) && room;
    assign issue_last = (idx_reg == len_reg - AW'(1));
    assign raddr      = start_reg + idx_reg;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr_reg] <= wdata;
        if (issue)
            ram_q <= mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            start_reg  <= '0;
            len_reg    <= '0;
            idx_reg    <= '0;
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
        end else begin
            rvalid_reg <= issue;
            rlast_reg  <= issue && issue_last;
            case (state_reg)
                ST_IDLE: begin
                    if (blk_req && (blk_len != '0)) begin
                        start_reg <= blk_start;
                        len_reg   <= blk_len;
                        idx_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        idx_reg <= idx_reg + AW'(1);
                        if (issue_last)
                            state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && rd_last)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign blk_busy = (state_reg != ST_IDLE);

    raw_skid #(
        .W (MW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rvalid_reg),
        .in_data   (ram_q),
        .in_last   (rlast_reg),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (skid_data),
        .out_last  (rd_last),
        .level     (skid_level)
    );

    assign rd_data = skid_data[WIDTH-1:0];

`ifdef RAW_RING_PARITY_EN
    logic par_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_err_reg <= 1'b0;
        else if (pop && (^skid_data))
            par_err_reg <= 1'b1;
    end

    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_raw_ring_buffer.sv
// Randomized scoreboard bench for raw_ring_buffer against a queue/array reference model.
module tb_raw_ring_buffer;

    localparam int W      = 288;
    localparam int AW     = 8;
    localparam int MARGIN = 10;
    localparam int CNTW   = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [W-1:0]    dw;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   keep_ptr;
    logic [AW-1:0]   wblock;
    logic            full;
    logic [CNTW-1:0] drop_cnt;
    logic            blk_req;
    logic [AW-1:0]   blk_start;
    logic [AW-1:0]   blk_len;
    logic            blk_busy;
    logic            rd_valid;
    logic            rd_ready;
    logic [W-1:0]    rd_data;
    logic            rd_last;
    logic            par_err;

    always #5 clk = ~clk;

    raw_ring_buffer #(
        .WIDTH  (W),
        .AW     (AW),
        .MARGIN (MARGIN),
        .CNTW   (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .dw        (dw),
        .wr_ptr    (wr_ptr),
        .keep_ptr  (keep_ptr),
        .wblock    (wblock),
        .full      (full),
        .drop_cnt  (drop_cnt),
        .blk_req   (blk_req),
        .blk_start (blk_start),
        .blk_len   (blk_len),
        .blk_busy  (blk_busy),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .par_err   (par_err)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] data;
        bit           last;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] ref_mem [256];
    int           m_wr, m_drop;
    bit           m_full;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++)
            w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference write side: free space, overrun suppression and the guard band from pointer arithmetic.
    initial begin : write_model
        int  space;
        bit  nf;
        m_wr = 0; m_drop = 0; m_full = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_wr = 0; m_drop = 0; m_full = 0;
            end else begin
                space = (int'(keep_ptr) - m_wr + 256) % 256;
                nf = !((space > int'(wblock) + MARGIN) || (space == 0));
                if (we) begin
                    if (space == 1) begin
                        if (m_drop < (1 << CNTW) - 1) m_drop++;
                    end else begin
                        ref_mem[m_wr] = dw;
                        m_wr = (m_wr + 1) % 256;
                    end
                end
                m_full = nf;
            end
        end
    end

    initial begin : write_checker
        forever begin
            @(negedge clk);
            chk("wr_ptr", W'(wr_ptr), W'(m_wr));
            chk("drop_cnt", W'(drop_cnt), W'(m_drop));
            chk("full", W'(full), W'(m_full));
            chk("par_err", W'(par_err), '0);
        end
    end

    // Read monitor: pops the scoreboard on each handshake and checks stability while stalled.
    initial begin : read_monitor
        exp_t         e;
        bit           holding;
        logic [W-1:0] hold_data;
        logic         hold_last;
        holding = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                holding = 0;
            end else begin
                if (holding) begin
                    chk("stall_valid", W'(rd_valid), W'(1));
                    chk("stall_data", rd_data, hold_data);
                    chk("stall_last", W'(rd_last), W'(hold_last));
                end
                if (rd_valid && rd_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_word");
                    end else begin
                        e = sb.pop_front();
                        chk("rd_data", rd_data, e.data);
                        chk("rd_last", W'(rd_last), W'(e.last));
                    end
                end
                holding   = rd_valid && !rd_ready;
                hold_data = rd_data;
                hold_last = rd_last;
            end
        end
    end

    task automatic write_until(input int keep, input int target, input int drops, input bit rand_wb);
        int c;
        keep_ptr = AW'(keep);
        for (c = 0; c < 2000 && m_wr != target; c++) begin
            we = ($urandom_range(0, 3) != 0);
            dw = rnd_word();
            if (rand_wb) wblock = AW'($urandom_range(0, 255));
            tick();
        end
        if (m_wr != target) fail_now("write_timeout");
        for (int i = 0; i < drops; i++) begin
            we = 1'b1;
            dw = rnd_word();
            tick();
        end
        we = 1'b0;
    endtask

    task automatic request(input int s, input int l);
        for (int n = 0; n < l; n++)
            sb.push_back('{data: ref_mem[(s + n) % 256], last: (n == l - 1)});
        blk_start = AW'(s);
        blk_len   = AW'(l);
        blk_req   = 1'b1;
        tick();
        blk_req   = 1'b0;
    endtask

    task automatic run_fast(input int s, input int l);
        rd_ready = 1'b1;
        request(s, l);
        @(negedge clk);
        chk("busy_rise", W'(blk_busy), W'(1));
        chk("valid_lat1", W'(rd_valid), '0);
        @(negedge clk);
        chk("valid_lat2", W'(rd_valid), '0);
        for (int k = 0; k < l; k++) begin
            @(negedge clk);
            chk("no_bubble", W'(rd_valid), W'(1));
            chk("last_pos", W'(rd_last), W'(k == l - 1));
        end
        @(negedge clk);
        chk("busy_fall", W'(blk_busy), '0);
        chk("sb_empty", W'(sb.size()), '0);
    endtask

    task automatic run_stall(input int s, input int l, input bit random_ready);
        int  c;
        bit  done;
        done = 0;
        request(s, l);
        for (c = 0; c < 1000; c++) begin
            rd_ready = random_ready ? 1'($urandom_range(0, 1))
                                    : (((c % 4) == 0) || ((c % 4) == 3));
            tick();
            if (!blk_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_now("block_timeout");
        rd_ready = 1'b1;
        chk("sb_empty", W'(sb.size()), '0);
    endtask

    initial begin : stimulus
        int hs;
        rst_n = 1'b0; we = 1'b0; dw = '0; keep_ptr = '0; wblock = 8'd20;
        blk_req = 1'b0; blk_start = '0; blk_len = '0; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_ptr", W'(wr_ptr), '0);
        chk("rst_full", W'(full), '0);
        chk("rst_drop", W'(drop_cnt), '0);
        chk("rst_busy", W'(blk_busy), '0);
        chk("rst_valid", W'(rd_valid), '0);
        chk("rst_last", W'(rd_last), '0);
        chk("rst_data", rd_data, '0);
        tick();
        rst_n = 1'b1;
        tick();

        write_until(0, 5, 0, 0);
        @(negedge clk);
        chk("five_writes", W'(wr_ptr), W'(5));
        tick();
        write_until(40, 39, 3, 0);
        write_until(200, 199, 2, 1);
        wblock = 8'd20;
        write_until(3, 2, 4, 0);
        repeat (3) tick();

        run_fast(250, 10);

        blk_start = 8'd7; blk_len = '0; blk_req = 1'b1;
        tick();
        blk_req = 1'b0;
        @(negedge clk);
        chk("len0_ignored", W'(blk_busy), '0);
        tick();

        run_stall(250, 10, 0);
        run_fast(17, 1);
        for (int i = 0; i < 4; i++)
            run_stall($urandom_range(0, 255), $urandom_range(1, 20), 1);

        rd_ready = 1'b1;
        request(250, 10);
        hs = 0;
        for (int c = 0; c < 100 && hs < 4; c++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) hs++;
        end
        if (hs < 4) fail_now("abort_setup_timeout");
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", W'(rd_valid), '0);
        chk("abort_busy", W'(blk_busy), '0);
        chk("abort_data", rd_data, '0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_tail_valid", W'(rd_valid), '0);
            chk("no_tail_busy", W'(blk_busy), '0);
        end
        tick();
        run_fast(100, 6);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
